// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared limits and Gray/binary helpers; zero-extended operands make the 32-bit helpers valid for any pointer width up to 32
package async_fifo_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int GW = 32;
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// async_fifo_rd_ctrl_if: read-side bundle; master drives wptr/rinc, slave returns raddr, rptr, rempty, ralmost_empty, rlevel, rerr_underflow
interface async_fifo_rd_ctrl_if #(parameter int ASIZE = 4);
  logic [ASIZE:0] wptr;
  logic rinc;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0] rptr;
  logic rempty;
  logic ralmost_empty;
  logic [ASIZE:0] rlevel;
  logic rerr_underflow;
  modport master(output wptr, rinc, input raddr, rptr, rempty, ralmost_empty, rlevel, rerr_underflow);
  modport slave(input wptr, rinc, output raddr, rptr, rempty, ralmost_empty, rlevel, rerr_underflow);
endinterface

// File: rtl/async_fifo_rd_ctrl_gray_sync_n.sv
// gray_sync_n: STAGES-deep flop chain (clk, async active-low rst_n, d in, q out) carrying a Gray pointer across clock domains
module gray_sync_n #(
  parameter int WIDTH = 5,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s [STAGES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < STAGES; i++) s[i] <= '0;
    else begin
      s[0] <= d;
      for (int i = 1; i < STAGES; i++) s[i] <= s[i-1];
    end
  assign q = s[STAGES-1];
endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// async_fifo_rd_ctrl: read-domain FIFO control (rclk, async active-low rrst_n, bus: wptr/rinc in; raddr, rptr, rempty, ralmost_empty, rlevel, rerr_underflow out)
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ASIZE = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH = 1
) (
  input logic rclk,
  input logic rrst_n,
  async_fifo_rd_ctrl_if.slave bus
);
  localparam int PW = ASIZE + 1;
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("async_fifo_rd_ctrl: SYNC_STAGES out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > 2 ** ASIZE) begin : g_bad_ae
    $error("async_fifo_rd_ctrl: AE_THRESH out of range");
  end
  logic [PW-1:0] wq, wbin, rbin, rbin_next, rgray_next, level_next;
  logic ren;
  gray_sync_n #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync (
    .clk(rclk),
    .rst_n(rrst_n),
    .d(bus.wptr),
    .q(wq)
  );
  assign wbin = PW'(gray2bin(32'(wq)));
  assign ren = bus.rinc & ~bus.rempty;
  assign rbin_next = rbin + PW'(ren);
  assign rgray_next = PW'(bin2gray(32'(rbin_next)));
  assign level_next = wbin - rbin_next;
  assign bus.raddr = rbin[ASIZE-1:0];
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      rbin <= '0;
      bus.rptr <= '0;
      bus.rempty <= 1'b1;
      bus.ralmost_empty <= 1'b1;
      bus.rlevel <= '0;
      bus.rerr_underflow <= 1'b0;
    end else begin
      rbin <= rbin_next;
      bus.rptr <= rgray_next;
      bus.rempty <= rgray_next == wq;
      bus.rlevel <= level_next;
      bus.ralmost_empty <= 32'(level_next) <= AE_THRESH;
      bus.rerr_underflow <= bus.rinc & bus.rempty;
    end
endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// tb_async_fifo_rd_ctrl: directed and randomized checks of two read controllers (SYNC 2/AE 2 and SYNC 3/AE 1) against a count-based model
module tb_async_fifo_rd_ctrl;
  localparam int SY [2] = '{2, 3};
  localparam int AE [2] = '{2, 1};
  logic clk = 0;
  logic rrst_n = 0;
  logic rinc = 0;
  int wcnt = 0;
  int checks = 0;
  int errors = 0;
  logic [4:0] wg;
  always #5 clk = ~clk;
  assign wg = 5'(wcnt ^ (wcnt >> 1));
  async_fifo_rd_ctrl_if #(.ASIZE(4)) ifa ();
  async_fifo_rd_ctrl_if #(.ASIZE(4)) ifb ();
  assign ifa.wptr = wg;
  assign ifa.rinc = rinc;
  assign ifb.wptr = wg;
  assign ifb.rinc = rinc;
  async_fifo_rd_ctrl #(.ASIZE(4), .SYNC_STAGES(2), .AE_THRESH(2)) dut_a (.rclk(clk), .rrst_n(rrst_n), .bus(ifa));
  async_fifo_rd_ctrl #(.ASIZE(4), .SYNC_STAGES(3), .AE_THRESH(1)) dut_b (.rclk(clk), .rrst_n(rrst_n), .bus(ifb));
  logic [4:0] o_rptr [2];
  logic [4:0] o_lvl [2];
  logic [3:0] o_addr [2];
  logic o_e [2];
  logic o_ae [2];
  logic o_uf [2];
  assign o_rptr[0] = ifa.rptr;
  assign o_rptr[1] = ifb.rptr;
  assign o_lvl[0] = ifa.rlevel;
  assign o_lvl[1] = ifb.rlevel;
  assign o_addr[0] = ifa.raddr;
  assign o_addr[1] = ifb.raddr;
  assign o_e[0] = ifa.rempty;
  assign o_e[1] = ifb.rempty;
  assign o_ae[0] = ifa.ralmost_empty;
  assign o_ae[1] = ifb.ralmost_empty;
  assign o_uf[0] = ifa.rerr_underflow;
  assign o_uf[1] = ifb.rerr_underflow;

  // Model: counts of writes seen and reads done, with the write count delayed by the sync depth.
  int m_r [2];
  int m_lvl [2];
  bit m_e [2];
  bit m_ae [2];
  bit m_uf [2];
  int pipe [2][4];

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_r[d] = 0;
      m_lvl[d] = 0;
      m_e[d] = 1;
      m_ae[d] = 1;
      m_uf[d] = 0;
      for (int i = 0; i < 4; i++) pipe[d][i] = 0;
    end
  endtask

  task automatic m_update();
    for (int d = 0; d < 2; d++) begin
      int wq;
      bit ren;
      wq = pipe[d][SY[d]-1];
      ren = rinc && !m_e[d];
      m_uf[d] = rinc && m_e[d];
      m_r[d] = (m_r[d] + int'(ren)) % 32;
      m_lvl[d] = (wq - m_r[d] + 32) % 32;
      m_e[d] = m_lvl[d] == 0;
      m_ae[d] = m_lvl[d] <= AE[d];
      for (int i = 3; i > 0; i--) pipe[d][i] = pipe[d][i-1];
      pipe[d][0] = wcnt;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rrst_n) m_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rrst_n = 0;
    rinc = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rrst_n = 1;
  endtask

  task automatic test_reset();
    rrst_n = 0;
    rinc = 0;
    wcnt = 3;
    m_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_e[d] !== 1'b1 || o_ae[d] !== 1'b1 || o_lvl[d] !== 5'd0 || o_rptr[d] !== 5'd0 || o_addr[d] !== 4'd0 || o_uf[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d got e=%b ae=%b lvl=%0d rptr=%b addr=%0d uf=%b want e=1 ae=1 lvl=0 rptr=0 addr=0 uf=0", d, o_e[d], o_ae[d], o_lvl[d], o_rptr[d], o_addr[d], o_uf[d]);
      end
    end
    rrst_n = 1;
  endtask

  task automatic test_sync_latency();
    for (int n = 1; n <= 4; n++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        logic exp_e;
        logic [4:0] exp_l;
        exp_e = n <= SY[d];
        exp_l = exp_e ? 5'd0 : 5'd3;
        checks++;
        if (o_e[d] !== exp_e || o_lvl[d] !== exp_l) begin
          errors++;
          $display("FAIL sync_latency dut%0d edge %0d got e=%b lvl=%0d want e=%b lvl=%0d", d, n, o_e[d], o_lvl[d], exp_e, exp_l);
        end
      end
    end
  endtask

  task automatic test_drain();
    rinc = 1;
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_addr[d] !== 4'(k) || o_lvl[d] !== 5'(3 - k) || o_e[d] !== 1'b0) begin
          errors++;
          $display("FAIL drain dut%0d k=%0d got addr=%0d lvl=%0d e=%b want addr=%0d lvl=%0d e=0", d, k, o_addr[d], o_lvl[d], o_e[d], k, 3 - k);
        end
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_lvl[d] !== 5'd0 || o_e[d] !== 1'b1 || o_rptr[d] !== 5'b00010 || o_addr[d] !== 4'd3) begin
        errors++;
        $display("FAIL drain_end dut%0d got lvl=%0d e=%b rptr=%b addr=%0d want lvl=0 e=1 rptr=00010 addr=3", d, o_lvl[d], o_e[d], o_rptr[d], o_addr[d]);
      end
    end
  endtask

  task automatic test_underflow();
    rinc = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) rinc = 0;
      step();
      for (int d = 0; d < 2; d++) begin
        logic exp_uf;
        exp_uf = k < 2;
        checks++;
        if (o_uf[d] !== exp_uf || o_rptr[d] !== 5'b00010) begin
          errors++;
          $display("FAIL underflow dut%0d cyc %0d got uf=%b rptr=%b want uf=%b rptr=00010", d, k, o_uf[d], o_rptr[d], exp_uf);
        end
      end
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    wcnt = 16;
    repeat (4) step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_lvl[d] !== 5'd16 || o_e[d] !== 1'b0 || o_ae[d] !== 1'b0) begin
        errors++;
        $display("FAIL full dut%0d got lvl=%0d e=%b ae=%b want lvl=16 e=0 ae=0", d, o_lvl[d], o_e[d], o_ae[d]);
      end
    end
    rinc = 1;
    for (int k = 0; k < 16; k++) begin
      logic [4:0] prev [2];
      for (int d = 0; d < 2; d++) begin
        prev[d] = o_rptr[d];
        checks++;
        if (o_addr[d] !== 4'(k) || o_lvl[d] !== 5'(16 - k)) begin
          errors++;
          $display("FAIL full_read dut%0d k=%0d got addr=%0d lvl=%0d want addr=%0d lvl=%0d", d, k, o_addr[d], o_lvl[d], k, 16 - k);
        end
      end
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ($countones(prev[d] ^ o_rptr[d]) != 1) begin
          errors++;
          $display("FAIL gray_step dut%0d got %b -> %b want one bit change", d, prev[d], o_rptr[d]);
        end
      end
    end
    rinc = 0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_rptr[d] !== 5'b11000 || o_addr[d] !== 4'd0 || o_e[d] !== 1'b1) begin
        errors++;
        $display("FAIL wrap dut%0d got rptr=%b addr=%0d e=%b want rptr=11000 addr=0 e=1", d, o_rptr[d], o_addr[d], o_e[d]);
      end
    end
  endtask

  task automatic test_almost_empty();
    do_reset();
    wcnt = 5;
    repeat (4) step();
    rinc = 1;
    for (int l = 5; l >= 0; l--) begin
      checks++;
      if (o_lvl[0] !== 5'(l) || o_ae[0] !== (l <= 2)) begin
        errors++;
        $display("FAIL almost_empty level %0d got lvl=%0d ae=%b want ae=%b", l, o_lvl[0], o_ae[0], l <= 2);
      end
      step();
    end
    rinc = 0;
    wcnt = 10;
    repeat (4) step();
    rinc = 1;
    repeat (2) step();
    rrst_n = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_e[d] !== 1'b1 || o_ae[d] !== 1'b1 || o_lvl[d] !== 5'd0 || o_rptr[d] !== 5'd0 || o_addr[d] !== 4'd0 || o_uf[d] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset dut%0d got e=%b ae=%b lvl=%0d rptr=%b addr=%0d uf=%b want e=1 ae=1 lvl=0 rptr=0 addr=0 uf=0", d, o_e[d], o_ae[d], o_lvl[d], o_rptr[d], o_addr[d], o_uf[d]);
      end
    end
    rinc = 0;
    m_reset();
    @(negedge clk);
    rrst_n = 1;
  endtask

  task automatic test_random();
    wcnt = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [4:0] prev [2];
      for (int d = 0; d < 2; d++) begin
        prev[d] = o_rptr[d];
        checks++;
        if (o_e[d] !== m_e[d] || o_ae[d] !== m_ae[d] || o_uf[d] !== m_uf[d] || o_lvl[d] !== 5'(m_lvl[d]) || o_addr[d] !== 4'(m_r[d] % 16) || o_rptr[d] !== 5'(m_r[d] ^ (m_r[d] >> 1))) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d got e=%b ae=%b uf=%b lvl=%0d addr=%0d rptr=%b want e=%b ae=%b uf=%b lvl=%0d addr=%0d rptr=%b", d, c, o_e[d], o_ae[d], o_uf[d], o_lvl[d], o_addr[d], o_rptr[d], m_e[d], m_ae[d], m_uf[d], m_lvl[d], m_r[d] % 16, 5'(m_r[d] ^ (m_r[d] >> 1)));
        end
      end
      rinc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && (wcnt - m_r[0] + 32) % 32 < 16 && (wcnt - m_r[1] + 32) % 32 < 16) wcnt = (wcnt + 1) % 32;
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ($countones(prev[d] ^ o_rptr[d]) > 1) begin
          errors++;
          $display("FAIL random_gray dut%0d cyc %0d got %b -> %b want at most one bit change", d, c, prev[d], o_rptr[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_drain();
    test_underflow();
    test_full_wrap();
    test_almost_empty();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
- Read-domain control for the debug async FIFO. Generalises the fixed two-flop write-pointer synchroniser.
- Synchronises the Gray-coded write pointer through a configurable number of flop stages and converts it to binary.
- Generates the read pointer and address; produces registered empty, almost-empty, fill-level and underflow-error outputs.
- Sits between the write-side control (source of wptr) and the dual-port RAM read port.

Parameters:
ASIZE, 4, address width; FIFO depth = 2^ASIZE; pointers are ASIZE+1 bits.
SYNC_STAGES, 2, number of synchroniser flops on wptr; legal range 2..4.
AE_THRESH, 1, ralmost_empty asserts when fill level <= AE_THRESH; legal range 0..2^ASIZE.

Ports:
rclk  in  1  read clock
rrst_n  in  1  read-domain reset
wptr  in  ASIZE+1  Gray write pointer from the write domain (asynchronous)
rinc  in  1  read request; honoured only when rempty=0
raddr  out  ASIZE  RAM read address (binary)
rptr  out  ASIZE+1  Gray read pointer, registered, sent to the write domain
rempty  out  1  FIFO empty, registered
ralmost_empty  out  1  level <= AE_THRESH, registered
rlevel  out  ASIZE+1  fill level seen from the read side, registered
rerr_underflow  out  1  one-cycle pulse: rinc asserted while rempty=1

Interface: reset rrst_n, asynchronous, active-low; clock rclk.

Behaviour:
- Reset (all flops async-cleared):
  - rptr=0, internal rbin=0, raddr=0, all sync stages=0, rlevel=0
  - rempty=1, ralmost_empty=1, rerr_underflow=0
- Synchroniser: shift register of SYNC_STAGES flops, each ASIZE+1 wide, no logic between stages. wq = last stage.
- Gray to binary on wq is combinational: wbin[ASIZE]=wq[ASIZE]; wbin[i]=wbin[i+1]^wq[i].
- Read advance: ren = rinc & ~rempty. rbin_next = rbin + ren, modulo 2^(ASIZE+1). rgray_next = (rbin_next>>1)^rbin_next.
- Registered updates on each rclk edge:
  - rbin<=rbin_next, rptr<=rgray_next
  - rempty<=(rgray_next==wq)
  - rlevel<=(wbin - rbin_next), modulo 2^(ASIZE+1)
  - ralmost_empty<=(that level <= AE_THRESH)
  - rerr_underflow<=rinc & rempty
- raddr = rbin[ASIZE-1:0], so data for the current head is addressed while rempty=0.
- Latency:
  - A wptr change reaches rempty/rlevel SYNC_STAGES+1 rclk edges after it is stable at the input.
  - A read updates rptr, raddr, rempty and rlevel on the same edge it is accepted.
- Pointer wrap: binary wraps 2^(ASIZE+1)-1 -> 0 and the Gray pointer stays single-bit-change. The MSB distinguishes laps, so level = 2^ASIZE (full) is representable.
- Read on the last entry: rempty asserts on the same edge. A further rinc is ignored and pulses rerr_underflow; rptr is unchanged.
- Simultaneous write arrival and read: the level uses the new wq and rbin_next, so it stays consistent. The level is pessimistic (may under-report), never over-reports.
- Reset mid-operation: everything returns to reset values asynchronously. The write domain must be reset in the same window; this block does not check that.
- Out-of-range parameters: stop elaboration via a generate-time error.

Decomposition:
- Shared package async_fifo_pkg holds:
  - SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4
  - functions gray2bin and bin2gray, parametrised by width
- One sub-module, gray_sync_n (WIDTH, STAGES, clk, rst_n, d, q). It is reused by the write-side control for rptr.

Test Plan:
- Reset values: hold rrst_n=0 with wptr=5'b00010 -> rempty=1, ralmost_empty=1, rlevel=0, rptr=0, raddr=0, rerr_underflow=0. Release reset.
- Sync latency (ASIZE=4, SYNC_STAGES=2): set wptr=5'b00010 (bin 3) -> rempty=1 for 2 edges, then rempty=0 and rlevel=3 on the 3rd edge. Repeat with SYNC_STAGES=3 -> 4th edge.
- Drain: wptr bin 3, hold rinc=1 -> raddr goes 0,1,2; rlevel goes 3,2,1,0; rempty=1 after the third accepted read; rptr=5'b00010.
- Underflow: with rempty=1, hold rinc=1 for 2 cycles -> rerr_underflow high for 2 cycles, rptr unchanged. Deassert -> rerr_underflow=0 next edge.
- Full and wrap: drive wptr to bin 16 (Gray 5'b11000) -> rlevel=16. Read 16 -> raddr wraps 15->0 and rptr=5'b11000. Continue through bin 31 (Gray 5'b10000) -> 0 with no multi-bit rptr change.
- Almost-empty (AE_THRESH=2): level 5, read one per cycle -> ralmost_empty=0 at levels 5,4,3 and 1 at levels 2,1,0. Assert rrst_n=0 mid-drain -> all outputs return to reset values immediately.
